jtvigil_scr2_lbuf: RTL and testbench

- Background (scroll 2) line renderer for the Vigilante video path.
- Fetches 4bpp background graphics from SDRAM through the standard rom_cs/rom_ok handshake, one line ahead of display.
- Unpacks each 32-bit word into 8 pixels and writes them into a double-buffered line buffer.
- Streams the previous line's pixels to the colour mixer at pxl_cen, indexed by the horizontal counter.

---
 rtl/jtvigil_scr2_lbuf.sv | 155 +++++++++++++++
 tb/tb_jtvigil_scr2_lbuf.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/jtvigil_scr2_lbuf.sv
// Vigilante scroll-2 background line renderer: fetches the next line's 4bpp
// graphics from ROM into one bank of a double line buffer while the other bank is shown.
module jtvigil_scr2_lbuf #(
    parameter int         FETCH_WORDS = 33,
    parameter logic [8:0] HSTART      = 9'd0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pxl_cen,
    input  logic        hs,
    input  logic [8:0]  h,
    input  logic [8:0]  v,
    input  logic [10:0] scrpos,
    output logic [17:0] rom_addr,
    input  logic [31:0] rom_data,
    output logic        rom_cs,
    input  logic        rom_ok,
    output logic [3:0]  pxl
);
    localparam int NW = $clog2(FETCH_WORDS + 1);
    localparam int AW = NW + 4;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, WRITE} state_t;

    state_t        state_q, state_d;
    logic          bank_q, bank_d;
    logic          hs_last_q, hs_last_d;
    logic [10:0]   scr_q, scr_d;
    logic [7:0]    vn_q, vn_d;
    logic [NW-1:0] n_q, n_d;
    logic [2:0]    k_q, k_d;
    logic          wait_first_q, wait_first_d;
    logic [31:0]   data_q, data_d;
    logic          rom_cs_q, rom_cs_d;
    logic [17:0]   rom_addr_q, rom_addr_d;
    logic [3:0]    pxl_q, pxl_d;

    logic          line_start;
    logic [7:0]    col;
    logic [AW-1:0] wr_a;
    logic          wr_en;
    logic [3:0]    wr_nib;
    logic [8:0]    hr;
    logic          unused_vmsb;

    logic [3:0] mem [0:511];

    assign unused_vmsb = v[8];
    assign line_start  = hs & ~hs_last_q;
    // Column of word n: (scr + 8n) >> 3, which wraps naturally at 2048 pixels
    assign col    = scr_q[10:3] + 8'(n_q);
    assign wr_a   = {1'b0, n_q, k_q} - AW'(scr_q[2:0]);
    assign wr_nib = data_q[{k_q, 2'b00} +: 4];
    assign hr     = h - HSTART;

    always_comb begin
        state_d      = state_q;
        bank_d       = bank_q;
        hs_last_d    = hs;
        scr_d        = scr_q;
        vn_d         = vn_q;
        n_d          = n_q;
        k_d          = k_q;
        wait_first_d = wait_first_q;
        data_d       = data_q;
        rom_cs_d     = rom_cs_q;
        rom_addr_d   = rom_addr_q;
        wr_en        = 1'b0;
        if (line_start) begin
            // A new line always wins, aborting any fetch still in flight
            bank_d   = ~bank_q;
            scr_d    = scrpos;
            vn_d     = v[7:0] + 8'd1;
            n_d      = '0;
            k_d      = '0;
            rom_cs_d = 1'b0;
            state_d  = REQ;
        end else begin
            case (state_q)
                REQ: begin
                    rom_addr_d   = {2'b00, col, vn_q};
                    rom_cs_d     = 1'b1;
                    wait_first_d = 1'b1;
                    state_d      = WAIT;
                end
                WAIT: begin
                    wait_first_d = 1'b0;
                    // rom_ok on the first cycle may still refer to the old address
                    if (!wait_first_q && rom_ok) begin
                        data_d   = rom_data;
                        rom_cs_d = 1'b0;
                        k_d      = '0;
                        state_d  = WRITE;
                    end
                end
                WRITE: begin
                    wr_en = (wr_a[AW-1:8] == '0);
                    k_d   = k_q + 3'd1;
                    if (k_q == 3'd7) begin
                        n_d     = n_q + 1'b1;
                        state_d = (n_q == NW'(FETCH_WORDS - 1)) ? IDLE : REQ;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        pxl_d = pxl_q;
        if (pxl_cen) begin
            pxl_d = hr[8] ? 4'd0 : mem[{~bank_q, hr[7:0]}];
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[{bank_q, wr_a[7:0]}] <= wr_nib;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            bank_q       <= 1'b0;
            hs_last_q    <= 1'b0;
            scr_q        <= '0;
            vn_q         <= '0;
            n_q          <= '0;
            k_q          <= '0;
            wait_first_q <= 1'b0;
            data_q       <= '0;
            rom_cs_q     <= 1'b0;
            rom_addr_q   <= '0;
            pxl_q        <= '0;
        end else begin
            state_q      <= state_d;
            bank_q       <= bank_d;
            hs_last_q    <= hs_last_d;
            scr_q        <= scr_d;
            vn_q         <= vn_d;
            n_q          <= n_d;
            k_q          <= k_d;
            wait_first_q <= wait_first_d;
            data_q       <= data_d;
            rom_cs_q     <= rom_cs_d;
            rom_addr_q   <= rom_addr_d;
            pxl_q        <= pxl_d;
        end
    end

    assign rom_cs   = rom_cs_q;
    assign rom_addr = rom_addr_q;
    assign pxl      = pxl_q;
endmodule

// File: tb/tb_jtvigil_scr2_lbuf.sv
// Bench for jtvigil_scr2_lbuf: serves ROM requests, then reads the line back
// and compares every pixel against a model built from the scroll rules.
module tb_jtvigil_scr2_lbuf;
    localparam int FW = 33;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pxl_cen = 1'b0;
    logic        hs = 1'b0;
    logic [8:0]  h = '0;
    logic [8:0]  v = '0;
    logic [10:0] scrpos = '0;
    logic [31:0] rom_data = '0;
    logic        rom_ok = 1'b0;
    logic [17:0] rom_addr;
    logic        rom_cs;
    logic [3:0]  pxl;

    int n_checks = 0;
    int n_fail = 0;

    logic [31:0] words[$];
    logic [17:0] addrs[$];
    int          rise_cyc[$];

    jtvigil_scr2_lbuf dut (
        .clk(clk), .rst_n(rst_n), .pxl_cen(pxl_cen), .hs(hs), .h(h), .v(v),
        .scrpos(scrpos), .rom_addr(rom_addr), .rom_data(rom_data),
        .rom_cs(rom_cs), .rom_ok(rom_ok), .pxl(pxl)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_line(input logic [8:0] vv, input logic [10:0] ss);
        v = vv;
        scrpos = ss;
        hs = 1'b1;
        tick();
        hs = 1'b0;
        // Mid-line scroll changes must not affect the line just latched
        scrpos = 11'($urandom);
        $display("line start v=%0d scr=%0d", vv, ss);
    endtask

    // Answers requests: rom_ok after 'delay' cycles (or always high when const_ok)
    task automatic serve(input int delay, input bit const_ok, input int max_acks,
                         input int budget, input logic [31:0] base, input bit rnd);
        int cnt = 0;
        int acks = 0;
        int idle = 0;
        bit prev_cs = rom_cs;
        logic [17:0] cur = '0;
        words.delete();
        addrs.delete();
        rise_cyc.delete();
        for (int cyc = 0; cyc < budget; cyc++) begin
            if (rom_cs && !prev_cs) begin
                cur = rom_addr;
                addrs.push_back(rom_addr);
                rise_cyc.push_back(cyc);
                words.push_back(rnd ? $urandom : base + 32'(addrs.size() - 1));
                cnt = 0;
            end else if (rom_cs && (cnt % 4 == 1)) begin
                check("addr_stable", 32'(rom_addr), 32'(cur));
            end
            rom_data = (words.size() > 0) ? words[words.size() - 1] : 32'd0;
            rom_ok = const_ok ? 1'b1 : (rom_cs && cnt >= delay && acks < max_acks);
            prev_cs = rom_cs;
            cnt++;
            tick();
            if (prev_cs && !rom_cs) acks++;
            if (acks >= max_acks && !rom_cs) idle++;
            if (idle > 10) break;
        end
        rom_ok = 1'b0;
    endtask

    task automatic verify_fetch(input logic [10:0] scr, input logic [8:0] vv, input int period);
        check("req_count", 32'(addrs.size()), FW);
        for (int n = 0; n < addrs.size(); n++) begin
            int x;
            logic [7:0] colv, rowv;
            x = (int'(scr) + 8 * n) % 2048;
            colv = 8'(x / 8);
            rowv = 8'((int'(vv) + 1) % 256);
            check($sformatf("rom_addr[%0d]", n), 32'(addrs[n]), {14'd0, colv, rowv});
            if (n > 0) check($sformatf("period[%0d]", n), rise_cyc[n] - rise_cyc[n-1], period);
        end
        $display("fetch scr=%0d v=%0d requests=%0d", scr, vv, addrs.size());
    endtask

    // Flip banks, then read back 256 visible pixels plus a few blanked ones
    task automatic readout(input logic [10:0] scr);
        start_line(9'($urandom), 11'($urandom));
        for (int i = 0; i < 260; i++) begin
            logic [31:0] exp;
            int j;
            j = i + int'(scr % 8);
            if (i < 256) exp = (words[j / 8] >> (4 * (j % 8))) & 32'hF;
            else exp = 0;
            h = 9'(i);
            pxl_cen = 1'b1;
            tick();
            pxl_cen = 1'b0;
            check($sformatf("pxl[h=%0d]", i), 32'(pxl), exp);
        end
        $display("readout scr=%0d done", scr);
    endtask

    initial begin
        logic [10:0] s;
        logic [8:0]  vv;
        int d;
        bit c;

        repeat (3) tick();
        check("rst_cs", 32'(rom_cs), 0);
        check("rst_addr", 32'(rom_addr), 0);
        check("rst_pxl", 32'(pxl), 0);
        rst_n = 1'b1;
        tick();

        // Reset while a request is outstanding
        start_line(9'd20, 11'd0);
        repeat (3) tick();
        check("midfetch_cs", 32'(rom_cs), 1);
        #3 rst_n = 1'b0;
        #1;
        check("async_cs", 32'(rom_cs), 0);
        check("async_addr", 32'(rom_addr), 0);
        check("async_pxl", 32'(pxl), 0);
        tick();
        rst_n = 1'b1;
        repeat (5) tick();
        check("idle_after_rst", 32'(rom_cs), 0);
        $display("reset mid-fetch done");

        // Directed: scroll 0, v=9, incrementing words
        start_line(9'd9, 11'd0);
        serve(1, 1'b0, FW, 3000, 32'h7654_3210, 1'b0);
        check("first_addr", 32'(addrs[0]), 32'h0000A);
        check("first_latency", rise_cyc[0], 1);
        verify_fetch(11'd0, 9'd9, 11);
        readout(11'd0);

        // Fine scroll of 3 drops the first three pixels
        start_line(9'd9, 11'd3);
        serve(1, 1'b0, FW, 3000, 32'h7654_3210, 1'b0);
        verify_fetch(11'd3, 9'd9, 11);
        readout(11'd3);

        // Column wrap, rom_ok held high
        start_line(9'd100, 11'd2040);
        serve(0, 1'b1, FW, 3000, 32'd0, 1'b1);
        check("wrap_col0", 32'(addrs[0][15:8]), 32'hFF);
        check("wrap_col1", 32'(addrs[1][15:8]), 32'h00);
        verify_fetch(11'd2040, 9'd100, 11);
        readout(11'd2040);

        // Random lines, including vertical wrap
        for (int t = 0; t < 4; t++) begin
            s = 11'($urandom);
            vv = (t == 0) ? 9'h1FF : 9'($urandom);
            d = $urandom_range(1, 4);
            c = (t == 1);
            start_line(vv, s);
            serve(d, c, FW, 3000, 32'd0, 1'b1);
            verify_fetch(s, vv, c ? 11 : 10 + d);
            readout(s);
        end

        // Slow ROM: the next hs aborts the fetch
        start_line(9'd50, 11'd77);
        serve(300, 1'b0, 2, 700, 32'd0, 1'b1);
        check("abort_pre_cs", 32'(rom_cs), 1);
        s = 11'd500;
        start_line(9'd60, s);
        check("abort_cs_drop", 32'(rom_cs), 0);
        tick();
        check("abort_cs_new", 32'(rom_cs), 1);
        check("abort_addr", 32'(rom_addr), {14'd0, s[10:3], 8'd61});
        $display("abort done");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
